writeback: RTL and testbench

registers (R0..R7), addressed by 3-bit indices.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 clock  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enable_writeback  input  1  qualifies a writeback in the current cycle.
REQ-007 W_Control  input  2  write-data select: 0 = aluout, 1 = memout, 2 = pcout, 3 = reserved (no write).
REQ-008 aluout  input  DATA_W  result from the execute stage.
REQ-009 memout  input  DATA_W  data from the memory-access stage.
REQ-010 pcout  input  DATA_W  computed PC/address value from the execute stage.
REQ-011 dr  input  3  destination register index.
REQ-012 sr1  input  3  read-port-1 register index.
REQ-013 sr2  input  3  read-port-2 register index.
REQ-014 d1  output  DATA_W  contents of register sr1.
REQ-015 d2  output  DATA_W  contents of register sr2.
REQ-016 psr  output  3  condition codes {N,Z,P} of the last written value.

Function
REQ-017 The block SHALL form wb_data as aluout, memout or pcout for W_Control 0, 1 or 2.
REQ-018 A write SHALL occur on a rising edge iff reset=0, enable_writeback=1 and W_Control!=3.
- On a write, R[dr] <= wb_data.
REQ-019 On a write, psr SHALL update on the same edge:
- 3'b100 if wb_data[15]=1.
- 3'b010 if wb_data==0.
- 3'b001 otherwise.
REQ-020 When no write occurs, the register file and psr SHALL hold their values.
- This covers enable_writeback=0 and W_Control=3 (reserved).
REQ-021 d1/d2 SHALL be asynchronous reads of R[sr1]/R[sr2], with zero-cycle latency from sr1/sr2 changes.
REQ-022 There SHALL be no write-to-read bypass.
- When sr1 or sr2 equals dr during a write cycle, d1/d2 show the old value until after the edge.
- The new value is visible in the following cycle.
REQ-023 Write latency SHALL be one cycle: data presented with enable_writeback in cycle N is readable in cycle N+1.
REQ-024 sr1==sr2 SHALL return identical data on both ports.
REQ-025 R0 SHALL be an ordinary writable register, with no hard-wired zero.
REQ-026 Changes to dr, W_Control or data inputs while enable_writeback=0 SHALL have no effect on state.
REQ-027 There SHALL be no internal arithmetic beyond the sign/zero test; wb_data is passed through at full DATA_W width.

Reset
REQ-028 On a rising edge with reset=1, all NUM_REGS registers SHALL become 0 and psr SHALL become 3'b010.
REQ-029 reset SHALL take priority over a simultaneous write; the write is discarded.
REQ-030 Following reset, d1=d2=16'h0000 for any sr1/sr2.
REQ-031 A reset asserted between back-to-back writes SHALL discard all earlier writes.
REQ-032 Writes SHALL resume on the first edge after reset deasserts.

Verification
REQ-033 Reset check: reset for 2 cycles, then sweep sr1/sr2 over 0..7 -> d1=d2=16'h0000 and psr=3'b010.
REQ-034 Write-select check:
- Stimulus: enable_writeback=1, dr=3, W_Control=0/1/2 on successive cycles, with aluout=16'h1234, memout=16'h8001, pcout=16'h0000.
- Response: with sr1=3, d1 reads 16'h1234, then 16'h8001, then 16'h0000, one cycle after each write.
- Response: psr reads 3'b001, then 3'b100, then 3'b010.
REQ-035 Suppression check: enable_writeback=0, or W_Control=3, with dr=5 and aluout=16'hFFFF -> R5 and psr unchanged.
REQ-036 Read-during-write check:
- Stimulus: R2=16'h00AA; write dr=2, aluout=16'h0055, sr1=sr2=2.
- Response: d1=d2=16'h00AA in the write cycle, then 16'h0055 in the next cycle.
REQ-037 Reset-priority check: reset=1 and a write of 16'h7777 to R7 in the same cycle -> R7=16'h0000, psr=3'b010.
REQ-038 Full-file check:
- Stimulus: write R0..R7 with values 16'h1000+i on 8 consecutive cycles.
- Response: read back all pairs (sr1=i, sr2=7-i) -> both ports return the expected values, with no aliasing.

---
 rtl/writeback.sv | 94 +++++++++
 tb/tb_writeback.sv | 134 +++++++++++++
 2 files changed

// File: rtl/writeback.sv
// -----------------------------------------------------------------------------
// writeback
// Writeback stage and general-purpose register file. Selects the writeback
// data from the execute/memory results, writes it into R[dr] on a qualified
// rising edge, tracks {N,Z,P} condition codes of the last written value, and
// provides two asynchronous read ports.
//
// Ports
//   clock            in   1       sole clock, rising-edge state updates
//   reset            in   1       synchronous, active-high reset
//   enable_writeback in   1       qualifies a write in this cycle
//   W_Control        in   2       0=aluout, 1=memout, 2=pcout, 3=no write
//   aluout           in   DATA_W  execute-stage result
//   memout           in   DATA_W  memory-stage data
//   pcout            in   DATA_W  computed PC/address value
//   dr               in   3       destination register index
//   sr1, sr2         in   3       read-port register indices
//   d1, d2           out  DATA_W  R[sr1], R[sr2] (combinational read)
//   psr              out  3       condition codes {N,Z,P}
// -----------------------------------------------------------------------------
module writeback #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned NUM_REGS = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable_writeback,
    input  logic [1:0]        W_Control,
    input  logic [DATA_W-1:0] aluout,
    input  logic [DATA_W-1:0] memout,
    input  logic [DATA_W-1:0] pcout,
    input  logic [2:0]        dr,
    input  logic [2:0]        sr1,
    input  logic [2:0]        sr2,
    output logic [DATA_W-1:0] d1,
    output logic [DATA_W-1:0] d2,
    output logic [2:0]        psr
);

    localparam logic [1:0] SEL_ALU = 2'd0;
    localparam logic [1:0] SEL_MEM = 2'd1;
    localparam logic [1:0] SEL_PC  = 2'd2;

    localparam logic [2:0] PSR_N = 3'b100;
    localparam logic [2:0] PSR_Z = 3'b010;
    localparam logic [2:0] PSR_P = 3'b001;

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [2:0]        r_psr;

    logic [DATA_W-1:0] w_wb_data;
    logic              w_wr_en;
    logic [2:0]        w_psr_next;

    // Writeback data select; the reserved encoding writes nothing.
    always_comb begin
        w_wb_data = '0;
        case (W_Control)
            SEL_ALU: w_wb_data = aluout;
            SEL_MEM: w_wb_data = memout;
            SEL_PC:  w_wb_data = pcout;
            default: w_wb_data = '0;
        endcase
    end

    assign w_wr_en = enable_writeback && (W_Control != 2'd3);

    // Condition codes from the sign bit / zero test of the written value.
    always_comb begin
        w_psr_next = PSR_P;
        if (w_wb_data[DATA_W-1])
            w_psr_next = PSR_N;
        else if (w_wb_data == '0)
            w_psr_next = PSR_Z;
    end

    // Register file and psr; reset wins over a simultaneous write.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++)
                r_regs[i] <= '0;
            r_psr <= PSR_Z;
        end else if (w_wr_en) begin
            r_regs[dr] <= w_wb_data;
            r_psr      <= w_psr_next;
        end
    end

    // Asynchronous reads with no write bypass: new data appears after the edge.
    assign d1  = r_regs[sr1];
    assign d2  = r_regs[sr2];
    assign psr = r_psr;

endmodule

// File: tb/tb_writeback.sv
module tb_writeback;

    localparam int unsigned DATA_W = 16;

    logic              clock = 1'b0;
    logic              reset;
    logic              enable_writeback;
    logic [1:0]        W_Control;
    logic [DATA_W-1:0] aluout, memout, pcout;
    logic [2:0]        dr, sr1, sr2;
    logic [DATA_W-1:0] d1, d2;
    logic [2:0]        psr;

    int n_checks = 0;
    int n_fail   = 0;

    writeback #(.DATA_W(DATA_W), .NUM_REGS(8)) dut (
        .clock            (clock),
        .reset            (reset),
        .enable_writeback (enable_writeback),
        .W_Control        (W_Control),
        .aluout           (aluout),
        .memout           (memout),
        .pcout            (pcout),
        .dr               (dr),
        .sr1              (sr1),
        .sr2              (sr2),
        .d1               (d1),
        .d2               (d2),
        .psr              (psr)
    );

    always #5 clock = ~clock;

    // One record: inputs for a cycle, and the outputs expected in that cycle
    // before its rising edge (i.e. state left by the previous cycles).
    typedef struct {
        logic        rst;
        logic        en;
        logic [1:0]  wc;
        logic [15:0] alu;
        logic [15:0] mem;
        logic [15:0] pc;
        logic [2:0]  dr;
        logic [2:0]  s1;
        logic [2:0]  s2;
        logic [15:0] e_d1;
        logic [15:0] e_d2;
        logic [2:0]  e_psr;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic en, input logic [1:0] wc,
                         input logic [15:0] alu, input logic [15:0] mem, input logic [15:0] pc,
                         input logic [2:0] d, input logic [2:0] s1, input logic [2:0] s2);
        @(negedge clock);
        reset = rst; enable_writeback = en; W_Control = wc;
        aluout = alu; memout = mem; pcout = pc;
        dr = d; sr1 = s1; sr2 = s2;
        #1;
    endtask

    task automatic check_out(input string name, input logic [15:0] e1, input logic [15:0] e2,
                             input logic [2:0] ep);
        check({name, ".d1"}, d1, e1);
        check({name, ".d2"}, d2, e2);
        check({name, ".psr"}, 16'(psr), 16'(ep));
    endtask

    initial begin
        //            rst  en  wc     alu       mem       pc        dr    s1    s2    e_d1      e_d2      e_psr
        vecs[0]  = '{1'b0,1'b1,2'd0,16'h1234,16'h8001,16'h0000,3'd3,3'd3,3'd0,16'h0000,16'h0000,3'b010};
        vecs[1]  = '{1'b0,1'b1,2'd1,16'h1234,16'h8001,16'h0000,3'd3,3'd3,3'd0,16'h1234,16'h0000,3'b001};
        vecs[2]  = '{1'b0,1'b1,2'd2,16'h1234,16'h8001,16'h0000,3'd3,3'd3,3'd0,16'h8001,16'h0000,3'b100};
        vecs[3]  = '{1'b0,1'b0,2'd0,16'hFFFF,16'h0000,16'h0000,3'd5,3'd3,3'd5,16'h0000,16'h0000,3'b010};
        vecs[4]  = '{1'b0,1'b1,2'd3,16'hFFFF,16'hFFFF,16'hFFFF,3'd5,3'd5,3'd3,16'h0000,16'h0000,3'b010};
        vecs[5]  = '{1'b0,1'b0,2'd0,16'h0000,16'h0000,16'h0000,3'd0,3'd5,3'd5,16'h0000,16'h0000,3'b010};
        vecs[6]  = '{1'b0,1'b1,2'd0,16'h00AA,16'h0000,16'h0000,3'd2,3'd2,3'd2,16'h0000,16'h0000,3'b010};
        vecs[7]  = '{1'b0,1'b1,2'd0,16'h0055,16'h0000,16'h0000,3'd2,3'd2,3'd2,16'h00AA,16'h00AA,3'b001};
        vecs[8]  = '{1'b0,1'b0,2'd0,16'h0000,16'h0000,16'h0000,3'd0,3'd2,3'd2,16'h0055,16'h0055,3'b001};
        vecs[9]  = '{1'b0,1'b1,2'd1,16'h0000,16'h8000,16'h0000,3'd0,3'd0,3'd2,16'h0000,16'h0055,3'b001};
        vecs[10] = '{1'b0,1'b0,2'd0,16'h0000,16'h0000,16'h0000,3'd0,3'd0,3'd3,16'h8000,16'h0000,3'b100};

        reset = 1'b1; enable_writeback = 1'b0; W_Control = 2'd0;
        aluout = '0; memout = '0; pcout = '0; dr = '0; sr1 = '0; sr2 = '0;

        // Reset for two cycles, then sweep both read ports.
        drive(1'b1, 1'b0, 2'd0, 16'h0, 16'h0, 16'h0, 3'd0, 3'd0, 3'd0);
        drive(1'b1, 1'b0, 2'd0, 16'h0, 16'h0, 16'h0, 3'd0, 3'd0, 3'd0);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, 2'd0, 16'h0, 16'h0, 16'h0, 3'd0, 3'(i), 3'(7 - i));
            check_out($sformatf("reset_sweep[%0d]", i), 16'h0000, 16'h0000, 3'b010);
        end

        // Table: write select, suppression, read-during-write, R0 writable.
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].wc, vecs[i].alu, vecs[i].mem,
                  vecs[i].pc, vecs[i].dr, vecs[i].s1, vecs[i].s2);
            check_out($sformatf("vec[%0d]", i), vecs[i].e_d1, vecs[i].e_d2, vecs[i].e_psr);
        end

        // Reset priority: R7 written, then reset coincides with a write of 7777.
        drive(1'b0, 1'b1, 2'd0, 16'h1111, 16'h0, 16'h0, 3'd7, 3'd7, 3'd0);
        drive(1'b1, 1'b1, 2'd0, 16'h7777, 16'h0, 16'h0, 3'd7, 3'd7, 3'd0);
        check_out("pre_reset_r7", 16'h1111, 16'h8000, 3'b001);
        // Writes resume on the first edge after reset deasserts.
        drive(1'b0, 1'b1, 2'd0, 16'h0042, 16'h0, 16'h0, 3'd1, 3'd7, 3'd0);
        check_out("reset_prio", 16'h0000, 16'h0000, 3'b010);
        drive(1'b0, 1'b0, 2'd0, 16'h0, 16'h0, 16'h0, 3'd0, 3'd1, 3'd7);
        check_out("resume_after_reset", 16'h0042, 16'h0000, 3'b001);

        // Full file: write R0..R7 on consecutive cycles, read back mirrored pairs.
        for (int i = 0; i < 8; i++)
            drive(1'b0, 1'b1, 2'd0, 16'h1000 + 16'(i), 16'h0, 16'h0, 3'(i), 3'd0, 3'd0);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, 2'd0, 16'h0, 16'h0, 16'h0, 3'd0, 3'(i), 3'(7 - i));
            check_out($sformatf("full_file[%0d]", i), 16'h1000 + 16'(i),
                      16'h1000 + 16'(7 - i), 3'b001);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
